// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - note FIFO plus timed tone sequencer driving a tone generator
//
// Purpose: the CPU queues note words (tone + duration in ms) into a small FIFO.
// When enabled, the sequencer plays each note in turn. After each note it inserts
// an optional silent gap, and it pulses an interrupt once the queue has drained.
//
// Ports:
//   clk_125mhz  in   1   clock, all state on rising edge
//   reset       in   1   asynchronous, active-high reset
//   wr_stb      in   1   one-cycle write strobe
//   wr_addr     in   1   0 = note FIFO, 1 = control register
//   wr_data     in   16  note word {tone[3:0], dur_ms[11:0]} or control word
//   rd_data     out  32  status {19'b0, enable, state[1:0], overflow, empty, full, count[6:0]}
//   mode        out  8   tone code to tone generator (0 = silent)
//   busy        out  1   state is not IDLE
//   done_irq    out  1   one-cycle pulse when the queue drains
`timescale 1ns/1ps

module note_sequencer #(
    parameter int DEPTH       = 16,
    parameter int TICK_CYCLES = 125000,
    parameter int GAP_MS      = 5
) (
    input  logic        clk_125mhz,
    input  logic        reset,
    input  logic        wr_stb,
    input  logic        wr_addr,
    input  logic [15:0] wr_data,
    output logic [31:0] rd_data,
    output logic [7:0]  mode,
    output logic        busy,
    output logic        done_irq
);

    localparam int            AW        = $clog2(DEPTH);
    localparam int            PW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [11:0]   GAP_LAST  = 12'(GAP_MS - 1);
    localparam logic [6:0]    DEPTH_C   = 7'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [6:0]    r_count;
    logic          r_enable;
    logic          r_overflow;
    state_t        r_state;
    state_t        w_state_next;
    logic [7:0]    r_tone;
    logic [11:0]   r_dur;
    logic [PW-1:0] r_presc;
    logic [11:0]   r_ms;
    logic          r_done_irq;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_ctrl_wr;
    logic          w_flush;
    logic          w_clr_ovf;
    logic          w_tick;
    logic          w_note_end;
    logic          w_gap_end;
    logic [15:0]   w_head;

    assign w_full     = (r_count == DEPTH_C);
    assign w_empty    = (r_count == 7'd0);
    assign w_push     = wr_stb & ~wr_addr & ~w_full;
    assign w_ctrl_wr  = wr_stb & wr_addr;
    assign w_flush    = w_ctrl_wr & wr_data[1];
    assign w_clr_ovf  = w_ctrl_wr & wr_data[2];
    assign w_head     = r_mem[r_rd_ptr];

    // A tick is the last enabled cycle of a millisecond; with enable low the
    // prescaler holds, so no tick can occur and playback time is frozen.
    assign w_tick     = r_enable && (r_presc == TICK_LAST);
    assign w_note_end = w_tick && (r_ms == (r_dur - 12'd1));
    assign w_gap_end  = w_tick && (r_ms == GAP_LAST);

    // Note storage; no reset needed, validity is tracked by the pointers.
    always_ff @(posedge clk_125mhz) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk_125mhz or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 7'd0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 7'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 7'd1;
                2'b01:   r_count <= r_count - 7'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_125mhz or posedge reset) begin
        if (reset) begin
            r_enable   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_enable <= wr_data[0];
            end
            // A note store and a control store never share a strobe, so set
            // and clear of the sticky flag cannot collide.
            if (wr_stb && !wr_addr && w_full) begin
                r_overflow <= 1'b1;
            end else if (w_clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // The popped word is captured on the IDLE->LOAD edge because the FIFO head
    // moves on that same edge; rest tones are mapped to silence here.
    always_ff @(posedge clk_125mhz or posedge reset) begin
        if (reset) begin
            r_tone <= 8'd0;
            r_dur  <= 12'd0;
        end else if (w_pop) begin
            r_tone <= (w_head[15:12] >= 4'd14) ? 8'd0 : {4'd0, w_head[15:12]};
            r_dur  <= w_head[11:0];
        end
    end

    // Counters restart on every state change, which covers LOAD->PLAY,
    // PLAY->GAP and any flush.
    always_ff @(posedge clk_125mhz or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_ms    <= 12'd0;
        end else if (w_state_next != r_state) begin
            r_presc <= '0;
            r_ms    <= 12'd0;
        end else if ((r_state == S_PLAY || r_state == S_GAP) && r_enable) begin
            if (w_tick) begin
                r_presc <= '0;
                r_ms    <= r_ms + 12'd1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    // Drain interrupt: back to IDLE from an active state with nothing queued
    // after this edge; a flush never raises it.
    always_ff @(posedge clk_125mhz or posedge reset) begin
        if (reset) begin
            r_done_irq <= 1'b0;
        end else begin
            r_done_irq <= (r_state != S_IDLE) && (w_state_next == S_IDLE) &&
                          w_empty && !w_push && !w_flush;
        end
    end

    always_ff @(posedge clk_125mhz or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        if (w_flush) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_enable && !w_empty) begin
                        w_state_next = S_LOAD;
                        w_pop        = 1'b1;
                    end
                end
                S_LOAD: begin
                    w_state_next = (r_dur == 12'd0) ? S_IDLE : S_PLAY;
                end
                S_PLAY: begin
                    if (w_note_end) begin
                        w_state_next = (GAP_MS > 0) ? S_GAP : S_IDLE;
                    end
                end
                S_GAP: begin
                    if (w_gap_end) begin
                        w_state_next = S_IDLE;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Outputs decode straight from registers so an asynchronous reset silences
    // the tone generator without waiting for a clock edge.
    always_comb begin
        mode     = 8'd0;
        busy     = (r_state != S_IDLE);
        done_irq = r_done_irq;
        if (r_state == S_PLAY && r_enable) begin
            mode = r_tone;
        end
    end

    assign rd_data = {19'd0, r_enable, r_state, r_overflow, w_empty, w_full, r_count};

endmodule
